// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control blocks.
// Holds the hazard FSM state encoding plus the bubble/zero-register constants.
package mips_pipe_pkg;

    localparam int REG_W  = 5;
    localparam int CTRL_W = 8;

    typedef enum logic [0:0] {
        HAZ_RUN     = 1'b0,
        HAZ_MD_BUSY = 1'b1
    } haz_state_t;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
    localparam logic [REG_W-1:0]  REG_ZERO    = '0;

    // Issue cycle counts as the first EX cycle, so the wait counter starts at LAT-2.
    function automatic logic [3:0] md_load_val(input int lat);
        return (lat > 1) ? 4'(lat - 2) : 4'd0;
    endfunction

endpackage

// File: rtl/haz_md_timer.sv
// Loadable 4-bit down-counter with a done flag; times EX occupancy of a mul/div.
// done is high whenever the count has reached zero.
module haz_md_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_done
);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the ID/EX register: load-use stall, branch flush, mul/div occupancy.
// Optional performance counters (stall_cnt, flush_cnt) are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int REG_W  = mips_pipe_pkg::REG_W,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_muldiv,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    import mips_pipe_pkg::*;

    localparam logic [3:0] MD_LOAD = md_load_val(MD_LAT);

    haz_state_t        r_state;
    haz_state_t        w_state_nxt;
    logic              w_load_use;
    logic              w_pc_write;
    logic              w_ifid_write;
    logic              w_ifid_flush;
    logic [CTRL_W-1:0] w_ctrl;
    logic              w_md_load;
    logic              w_md_dec;
    logic              w_md_done;

    // Register 0 is hardwired, so a load targeting it can never feed a consumer.
    assign w_load_use = id_valid && ex_mem_read &&
                        (ex_rt != REG_W'(REG_ZERO)) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HAZ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_ctrl       = ctrl_in;
        w_md_load    = 1'b0;
        w_md_dec     = 1'b0;
        case (r_state)
            HAZ_RUN: begin
                if (ex_branch_taken) begin
                    w_ifid_flush = 1'b1;
                    w_ctrl       = CTRL_W'(CTRL_BUBBLE);
                end else if (w_load_use) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_ctrl       = CTRL_W'(CTRL_BUBBLE);
                end else if (id_valid && id_is_muldiv) begin
                    if (MD_LAT > 1) begin
                        w_md_load   = 1'b1;
                        w_state_nxt = HAZ_MD_BUSY;
                    end
                end
            end
            HAZ_MD_BUSY: begin
                // EX holds the mul/div or a bubble here, so branch and load inputs are stale.
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_ctrl       = CTRL_W'(CTRL_BUBBLE);
                if (w_md_done) begin
                    w_state_nxt = HAZ_RUN;
                end else begin
                    w_md_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HAZ_RUN;
            end
        endcase
    end

    haz_md_timer u_md_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_md_load),
        .i_load_val (MD_LOAD),
        .i_dec      (w_md_dec),
        .o_done     (w_md_done)
    );

    // All enables are forced low while reset is held, not just the registered state.
    assign pc_write   = rst_n && w_pc_write;
    assign ifid_write = rst_n && w_ifid_write;
    assign ifid_flush = rst_n && w_ifid_flush;
    assign ctrl_out   = rst_n ? w_ctrl : CTRL_W'(CTRL_BUBBLE);
    assign md_busy    = rst_n && (r_state == HAZ_MD_BUSY);

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (!pc_write) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (ifid_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule
